// File: rtl/mclr_pkg.sv
// Shared types and constants for the master-clear pulse sequencer.
package mclr_pkg;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } mclr_state_e;

    // Depth of the optional input synchroniser.
    localparam int unsigned MCLR_SYNC_STAGES = 2;

    // Width of a channel index, never less than one bit.
    function automatic int unsigned ch_width(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/mclr_pulse_sequencer_if.sv
// Master-clear request in, per-channel clear pulses and status out.
interface mclr_pulse_sequencer_if #(
    parameter int unsigned N_CH = 4
);
    import mclr_pkg::*;

    localparam int unsigned CH_W = ch_width(N_CH);

    logic              master_clear;
    logic [N_CH-1:0]   ch_pulse;
    logic [CH_W-1:0]   active_ch;
    logic              busy;
    logic              done;

    // Requester side: raises master_clear, watches the pulse train.
    modport master (
        output master_clear,
        input  ch_pulse,
        input  active_ch,
        input  busy,
        input  done
    );

    // Sequencer side.
    modport slave (
        input  master_clear,
        output ch_pulse,
        output active_ch,
        output busy,
        output done
    );

endinterface

// File: rtl/mclr_sync2.sv
// Two-flop synchroniser for the board-level master-clear input.
module mclr_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    import mclr_pkg::*;

    logic [MCLR_SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[MCLR_SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[MCLR_SYNC_STAGES-1];

endmodule

// File: rtl/mclr_pulse_sequencer.sv
// Master-clear sequencer: one rising edge of master_clear produces an
// ordered train of PULSE_W-wide clear pulses, one per channel, separated
// by GAP_W idle cycles. REARM selects lock-out or return-to-idle after
// the train. Define MCLR_SYNC_EN to pass master_clear through a two-flop
// synchroniser (adds two cycles of latency).
module mclr_pulse_sequencer #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned REARM   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    mclr_pulse_sequencer_if.slave bus
);
    import mclr_pkg::*;

    localparam int unsigned CH_W = ch_width(N_CH);

    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

    mclr_state_e      state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_prev_q;
    logic             mc_in;
    logic             rise_c;

    logic [N_CH-1:0]  ch_pulse_q, ch_pulse_d;
    logic [CH_W-1:0]  active_ch_q, active_ch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef MCLR_SYNC_EN
    mclr_sync2 u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.master_clear),
        .sync_out (mc_in)
    );
`else
    assign mc_in = bus.master_clear;
`endif

    assign rise_c = mc_in & ~mc_prev_q;

    // Next-state logic and Moore decode of the next state into output values.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        ch_pulse_d  = '0;
        active_ch_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d = PULSE;
                    ch_d    = '0;
                    cnt_d   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else if (GAP_W == 0) begin
                        ch_d  = ch_q + CH_W'(1);
                        cnt_d = PULSE_LOAD;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    ch_d    = ch_q + CH_W'(1);
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (REARM != 0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs reflect the state being entered, so the registered copy
        // equals a decode of the state/ch registers with no extra latency.
        case (state_d)
            PULSE: begin
                ch_pulse_d  = N_CH'(1) << ch_d;
                active_ch_d = ch_d;
                busy_d      = 1'b1;
            end
            GAP: begin
                active_ch_d = ch_d + CH_W'(1);
                busy_d      = 1'b1;
            end
            DONE: begin
                active_ch_d = LAST_CH;
                done_d      = 1'b1;
            end
            default: begin
                active_ch_d = '0;
            end
        endcase
    end

    // State, counters, edge detector and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            mc_prev_q   <= 1'b0;
            ch_pulse_q  <= '0;
            active_ch_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            mc_prev_q   <= mc_in;
            ch_pulse_q  <= ch_pulse_d;
            active_ch_q <= active_ch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.ch_pulse  = ch_pulse_q;
    assign bus.active_ch = active_ch_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mclr_pulse_sequencer.sv
// Bench for mclr_pulse_sequencer: three configurations share one stimulus
// stream and are checked every cycle against an elapsed-time model.
module tb_mclr_pulse_sequencer;

`ifdef MCLR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam int NCFG = 3;
    // a: defaults with lock-out, b: defaults with re-arm, c: minimal config
    localparam int NCH [NCFG] = '{4, 4, 1};
    localparam int PW  [NCFG] = '{2, 2, 1};
    localparam int GW  [NCFG] = '{1, 1, 0};
    localparam int RA  [NCFG] = '{0, 1, 0};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic mc    = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    int tbl [11] = '{1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8};

    always #5 clk = ~clk;

    mclr_pulse_sequencer_if #(.N_CH(4)) if_a ();
    mclr_pulse_sequencer_if #(.N_CH(4)) if_b ();
    mclr_pulse_sequencer_if #(.N_CH(1)) if_c ();

    assign if_a.master_clear = mc;
    assign if_b.master_clear = mc;
    assign if_c.master_clear = mc;

    mclr_pulse_sequencer #(.N_CH(4), .PULSE_W(2), .GAP_W(1), .CNT_W(8), .REARM(0))
        dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    mclr_pulse_sequencer #(.N_CH(4), .PULSE_W(2), .GAP_W(1), .CNT_W(8), .REARM(1))
        dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    mclr_pulse_sequencer #(.N_CH(1), .PULSE_W(1), .GAP_W(0), .CNT_W(8), .REARM(0))
        dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: each config is either idle or m_p cycles past its trigger edge.
    bit m_act [NCFG];
    int m_p   [NCFG];
    bit m_prev, s0, s1, m_in, m_rise;

    function automatic int total_len(input int i);
        return NCH[i] * PW[i] + (NCH[i] - 1) * GW[i];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_prev = 1'b0; s0 = 1'b0; s1 = 1'b0;
            for (int i = 0; i < NCFG; i++) begin
                m_act[i] = 1'b0;
                m_p[i]   = 0;
            end
        end else begin
            m_in   = (LAT != 0) ? s1 : mc;
            m_rise = m_in & ~m_prev;
            for (int i = 0; i < NCFG; i++) begin
                if (!m_act[i]) begin
                    if (m_rise) begin
                        m_act[i] = 1'b1;
                        m_p[i]   = 0;
                    end
                end else if (m_p[i] < total_len(i)) begin
                    m_p[i]++;
                end else if (RA[i] != 0) begin
                    m_act[i] = 1'b0;
                end
            end
            m_prev = m_in;
            s1 = s0;
            s0 = mc;
        end
    end

    task automatic model_out(input int i, output int ep, output int ea,
                             output int eb, output int ed);
        int per, c, o;
        ep = 0; ea = 0; eb = 0; ed = 0;
        if (m_act[i]) begin
            if (m_p[i] >= total_len(i)) begin
                ed = 1;
                ea = NCH[i] - 1;
            end else begin
                per = PW[i] + GW[i];
                c   = m_p[i] / per;
                o   = m_p[i] % per;
                eb  = 1;
                if (o < PW[i]) begin
                    ep = 1 << c;
                    ea = c;
                end else begin
                    ea = c + 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int i, input string tag, input int p,
                             input int a, input int b, input int d);
        int ep, ea, eb, ed;
        model_out(i, ep, ea, eb, ed);
        cmp({tag, ".ch_pulse"},  p, ep);
        cmp({tag, ".active_ch"}, a, ea);
        cmp({tag, ".busy"},      b, eb);
        cmp({tag, ".done"},      d, ed);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_dut(0, "a", int'(if_a.ch_pulse), int'(if_a.active_ch), int'(if_a.busy), int'(if_a.done));
            check_dut(1, "b", int'(if_b.ch_pulse), int'(if_b.active_ch), int'(if_b.busy), int'(if_b.done));
            check_dut(2, "c", int'(if_c.ch_pulse), int'(if_c.active_ch), int'(if_c.busy), int'(if_c.done));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int  cnt, cnt_b, r0a, r0b, guard;
        bit  pa, pb, found;

        reset = 1'b1;
        mc    = 1'b0;
        cyc(3);
        cmp_en = 1'b1;
        cmp("reset ch_pulse",  int'(if_a.ch_pulse), 0);
        cmp("reset active_ch", int'(if_a.active_ch), 0);
        cmp("reset busy",      int'(if_a.busy), 0);
        cmp("reset done",      int'(if_a.done), 0);
        reset = 1'b0;
        cyc(3);

        // Basic one-cycle request.
        mc = 1'b1;
        @(negedge clk);
        mc = 1'b0;
        repeat (LAT) @(negedge clk);
        cnt = 0;
        for (int j = 0; j < 12; j++) begin
            if (j < 11) cmp("basic ch_pulse", int'(if_a.ch_pulse), tbl[j]);
            cmp("basic done", int'(if_a.done), (j == 11) ? 1 : 0);
            cnt += int'(if_a.busy);
            if (j == 0) begin
                cmp("min ch_pulse", int'(if_c.ch_pulse), 1);
                cmp("min done early", int'(if_c.done), 0);
            end
            if (j == 1) begin
                cmp("min done", int'(if_c.done), 1);
                cmp("min ch_pulse off", int'(if_c.ch_pulse), 0);
            end
            if (j == 11) cmp("rearm done", int'(if_b.done), 1);
            @(negedge clk);
        end
        cmp("basic busy cycles", cnt, 11);
        cmp("rearm done width", int'(if_b.done), 0);

        // Lock-out: second request after done produces nothing on config a.
        cyc(5);
        mc = 1'b1;
        @(negedge clk);
        mc = 1'b0;
        cnt = 0;
        repeat (20) begin
            cnt += (if_a.ch_pulse != 0) ? 1 : 0;
            @(negedge clk);
        end
        cmp("lockout pulses", cnt, 0);
        cmp("lockout done held", int'(if_a.done), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("post-reset done",      int'(if_a.done), 0);
        cmp("post-reset busy",      int'(if_a.busy), 0);
        cmp("post-reset ch_pulse",  int'(if_a.ch_pulse), 0);
        cmp("post-reset active_ch", int'(if_a.active_ch), 0);

        // Re-arm: two requests 20 cycles apart.
        cyc(3);
        cnt = 0;
        cnt_b = 0;
        for (int k = 0; k < 2; k++) begin
            mc = 1'b1;
            repeat (20) begin
                @(negedge clk);
                mc = 1'b0;
                cnt   += int'(if_b.done);
                cnt_b += (if_b.ch_pulse != 0) ? 1 : 0;
            end
        end
        cmp("rearm done count", cnt, 2);
        cmp("rearm pulse cycles", cnt_b, 16);

        // Level held for 30 cycles: exactly one train.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mc = 1'b1;
        r0a = 0; r0b = 0; pa = 1'b0; pb = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == 29) mc = 1'b0;
            if (if_a.ch_pulse[0] && !pa) r0a++;
            if (if_b.ch_pulse[0] && !pb) r0b++;
            pa = if_a.ch_pulse[0];
            pb = if_b.ch_pulse[0];
        end
        cmp("hold trains a", r0a, 1);
        cmp("hold trains b", r0b, 1);

        // Re-pulse mid-train: still one train.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mc = 1'b1;
        @(negedge clk);
        mc = 1'b0;
        r0b = (if_b.ch_pulse[0]) ? 1 : 0;
        pb  = if_b.ch_pulse[0];
        for (int k = 0; k < 20; k++) begin
            if (k == 4) mc = 1'b1;
            if (k == 5) mc = 1'b0;
            @(negedge clk);
            if (if_b.ch_pulse[0] && !pb) r0b++;
            pb = if_b.ch_pulse[0];
        end
        cmp("repulse trains b", r0b, 1);

        // Mid-sequence reset while channel 2 pulses.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        mc = 1'b1;
        @(negedge clk);
        mc = 1'b0;
        found = 1'b0;
        guard = 0;
        while (!found && guard < 40) begin
            if (if_a.ch_pulse == 4'b0100) found = 1'b1;
            else begin
                @(negedge clk);
                guard++;
            end
        end
        cmp("reach ch2 pulse", int'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("abort ch_pulse",  int'(if_a.ch_pulse), 0);
        cmp("abort active_ch", int'(if_a.active_ch), 0);
        cmp("abort busy",      int'(if_a.busy), 0);
        cmp("abort done",      int'(if_a.done), 0);
        cnt = 0;
        repeat (20) begin
            cnt += (if_a.ch_pulse != 0) ? 1 : 0;
            @(negedge clk);
        end
        cmp("idle after abort", cnt, 0);

        // Level high through reset release starts a fresh train at ch 0.
        mc = 1'b1;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        @(negedge clk);
        repeat (LAT) @(negedge clk);
        cmp("restart ch_pulse",  int'(if_a.ch_pulse), 1);
        cmp("restart active_ch", int'(if_a.active_ch), 0);
        cyc(20);
        mc = 1'b0;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
